// File: rtl/flash_arbiter_pkg.sv
// Shared definitions for the SPI flash ownership arbiter.
package flash_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRAIN = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_t;

    // Requester slots on the arbiter
    localparam int REQ_CHAN   = 0;  // channel-programming sequencer
    localparam int REQ_IPBUS  = 1;  // IPbus flash access
    localparam int REQ_REPROG = 2;  // master-reprogram sequencer

    localparam logic [23:0] FLASH_TIMEOUT_DEF = 24'hFF_FFFF;

    localparam int WBUF_AW = 7;
    localparam int CMD_W   = 32;
    localparam int NBITS_W = 12;

endpackage

// File: rtl/flash_arbiter_req_mux.sv
// Registered N-to-1 multiplexer of the per-requester flash command fields,
// selected by a one-hot grant. force_zero clears every output on the next edge.
module flash_req_mux
    import flash_arbiter_pkg::*;
#(
    parameter int N_REQ = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           sel,
    input  logic                       force_zero,
    input  logic [N_REQ-1:0]           in_store,
    input  logic [WBUF_AW*N_REQ-1:0]   in_addr,
    input  logic [CMD_W*N_REQ-1:0]     in_cmd,
    input  logic [NBITS_W*N_REQ-1:0]   in_nbits,
    input  logic [N_REQ-1:0]           in_send_wr,
    input  logic [N_REQ-1:0]           in_read_bs,
    output logic                       out_store,
    output logic [WBUF_AW-1:0]         out_addr,
    output logic [CMD_W-1:0]           out_cmd,
    output logic [NBITS_W-1:0]         out_nbits,
    output logic                       out_send_wr,
    output logic                       out_read_bs
);

    logic               m_store;
    logic [WBUF_AW-1:0] m_addr;
    logic [CMD_W-1:0]   m_cmd;
    logic [NBITS_W-1:0] m_nbits;
    logic               m_send_wr;
    logic               m_read_bs;

    // AND-OR select of the granted requester's fields
    always_comb begin
        m_store   = 1'b0;
        m_addr    = '0;
        m_cmd     = '0;
        m_nbits   = '0;
        m_send_wr = 1'b0;
        m_read_bs = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sel[i]) begin
                m_store   = m_store   | in_store[i];
                m_addr    = m_addr    | in_addr[WBUF_AW*i +: WBUF_AW];
                m_cmd     = m_cmd     | in_cmd[CMD_W*i +: CMD_W];
                m_nbits   = m_nbits   | in_nbits[NBITS_W*i +: NBITS_W];
                m_send_wr = m_send_wr | in_send_wr[i];
                m_read_bs = m_read_bs | in_read_bs[i];
            end
        end
    end

    // Output register stage towards spi_flash_intf
    always_ff @(posedge clk) begin
        if (reset || force_zero) begin
            out_store   <= 1'b0;
            out_addr    <= '0;
            out_cmd     <= '0;
            out_nbits   <= '0;
            out_send_wr <= 1'b0;
            out_read_bs <= 1'b0;
        end else begin
            out_store   <= m_store;
            out_addr    <= m_addr;
            out_cmd     <= m_cmd;
            out_nbits   <= m_nbits;
            out_send_wr <= m_send_wr;
            out_read_bs <= m_read_bs;
        end
    end

endmodule

// File: rtl/flash_arbiter.sv
// Fixed-priority, non-preemptive arbiter granting one requester at a time
// ownership of the SPI flash interface, with a grant watchdog.
//
// state | meaning
// IDLE  | no owner; grant lowest-index unmasked req
// GRANT | owner's fields forwarded downstream one register stage late
// DRAIN | owner released req with a command in flight; wait for its end pulse
// GAP   | one dead cycle with grant and all downstream outputs at zero
module flash_arbiter
    import flash_arbiter_pkg::*;
#(
    parameter int          N_REQ   = 3,
    parameter logic [23:0] TIMEOUT = FLASH_TIMEOUT_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    output logic [N_REQ-1:0]           grant,
    input  logic [N_REQ-1:0]           r_store_cmd,
    input  logic [WBUF_AW*N_REQ-1:0]   r_wbuf_addr,
    input  logic [CMD_W*N_REQ-1:0]     r_flash_cmd,
    input  logic [NBITS_W*N_REQ-1:0]   r_wr_nbits,
    input  logic [N_REQ-1:0]           r_send_wr,
    input  logic [N_REQ-1:0]           r_read_bs,
    output logic [N_REQ-1:0]           r_end_wr,
    output logic [N_REQ-1:0]           r_end_bs,
    output logic                       store_flash_command,
    output logic [WBUF_AW-1:0]         wbuf_address,
    output logic [CMD_W-1:0]           flash_command,
    output logic [NBITS_W-1:0]         flash_wr_nBits,
    output logic                       send_write_command,
    output logic                       read_bitstream,
    input  logic                       end_write_command,
    input  logic                       end_bitstream,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam logic [23:0] WD_LAST = TIMEOUT - 24'd1;

    arb_state_t         state, state_nx;
    logic [N_REQ-1:0]   grant_nx;
    logic [N_REQ-1:0]   to_mask;
    logic [N_REQ-1:0]   avail, pick;
    logic [23:0]        wd, wd_nx;
    logic               out_wr, out_bs, out_wr_nx, out_bs_nx;
    logic               wr_pend, bs_pend;
    logic               owner_req, wd_hit;
    logic               timeout_set, force_zero;

    assign avail     = req & ~to_mask;
    assign owner_req = |(req & grant);
    assign wd_hit    = (wd == WD_LAST);

    // A command counts as in flight from the cycle its start level is seen
    // downstream, so a req drop right after the start still drains.
    assign wr_pend = (out_wr | send_write_command) & ~end_write_command;
    assign bs_pend = (out_bs | read_bitstream)     & ~end_bitstream;

    assign busy     = (state != ST_IDLE);
    assign r_end_wr = grant & {N_REQ{end_write_command}};
    assign r_end_bs = grant & {N_REQ{end_bitstream}};

    // Lowest index wins among unmasked requests
    always_comb begin
        pick = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (avail[i]) begin
                pick    = '0;
                pick[i] = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // Next-state, grant, watchdog and in-flight bookkeeping
    always_comb begin
        state_nx    = state;
        grant_nx    = grant;
        wd_nx       = wd;
        out_wr_nx   = 1'b0;
        out_bs_nx   = 1'b0;
        timeout_set = 1'b0;
        force_zero  = 1'b1;
        case (state)
            ST_IDLE: begin
                grant_nx = '0;
                if (|avail) begin
                    grant_nx = pick;
                    wd_nx    = '0;
                    state_nx = ST_GRANT;
                end
            end
            ST_GRANT: begin
                out_wr_nx = wr_pend;
                out_bs_nx = bs_pend;
                wd_nx     = wd + 24'd1;
                if (wd_hit) begin
                    timeout_set = 1'b1;
                    grant_nx    = '0;
                    state_nx    = ST_GAP;
                end else if (!owner_req) begin
                    if (wr_pend || bs_pend) begin
                        state_nx = ST_DRAIN;
                    end else begin
                        grant_nx = '0;
                        state_nx = ST_GAP;
                    end
                end else begin
                    force_zero = 1'b0;
                end
            end
            ST_DRAIN: begin
                out_wr_nx = wr_pend;
                out_bs_nx = bs_pend;
                wd_nx     = wd + 24'd1;
                if (wd_hit) begin
                    timeout_set = 1'b1;
                    grant_nx    = '0;
                    state_nx    = ST_GAP;
                end else if (!(wr_pend || bs_pend)) begin
                    grant_nx = '0;
                    state_nx = ST_GAP;
                end
            end
            ST_GAP: begin
                grant_nx = '0;
                state_nx = ST_IDLE;
            end
            default: begin
                grant_nx = '0;
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Grant, watchdog, flags, timeout mask and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            grant       <= '0;
            wd          <= '0;
            out_wr      <= 1'b0;
            out_bs      <= 1'b0;
            to_mask     <= '0;
            timeout_err <= 1'b0;
        end else begin
            grant       <= grant_nx;
            wd          <= wd_nx;
            out_wr      <= out_wr_nx;
            out_bs      <= out_bs_nx;
            // a timed-out requester stays masked until its req is seen low
            to_mask     <= (to_mask | (timeout_set ? grant : '0)) & req;
            timeout_err <= timeout_err | timeout_set;
        end
    end

    flash_req_mux #(.N_REQ(N_REQ)) u_mux (
        .clk         (clk),
        .reset       (reset),
        .sel         (grant),
        .force_zero  (force_zero),
        .in_store    (r_store_cmd),
        .in_addr     (r_wbuf_addr),
        .in_cmd      (r_flash_cmd),
        .in_nbits    (r_wr_nbits),
        .in_send_wr  (r_send_wr),
        .in_read_bs  (r_read_bs),
        .out_store   (store_flash_command),
        .out_addr    (wbuf_address),
        .out_cmd     (flash_command),
        .out_nbits   (flash_wr_nBits),
        .out_send_wr (send_write_command),
        .out_read_bs (read_bitstream)
    );

endmodule

// File: tb/tb_flash_arbiter.sv
// Directed vector bench for flash_arbiter plus timeout and reset sequences.
module tb_flash_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req, grant, r_store_cmd, r_send_wr, r_read_bs, r_end_wr, r_end_bs;
    logic [20:0] r_wbuf_addr;
    logic [95:0] r_flash_cmd;
    logic [35:0] r_wr_nbits;
    logic        store_flash_command, send_write_command, read_bitstream;
    logic [6:0]  wbuf_address;
    logic [31:0] flash_command;
    logic [11:0] flash_wr_nBits;
    logic        end_write_command, end_bitstream, busy, timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    flash_arbiter #(.N_REQ(3), .TIMEOUT(24'd16)) dut (
        .clk                 (clk),
        .reset               (reset),
        .req                 (req),
        .grant               (grant),
        .r_store_cmd         (r_store_cmd),
        .r_wbuf_addr         (r_wbuf_addr),
        .r_flash_cmd         (r_flash_cmd),
        .r_wr_nbits          (r_wr_nbits),
        .r_send_wr           (r_send_wr),
        .r_read_bs           (r_read_bs),
        .r_end_wr            (r_end_wr),
        .r_end_bs            (r_end_bs),
        .store_flash_command (store_flash_command),
        .wbuf_address        (wbuf_address),
        .flash_command       (flash_command),
        .flash_wr_nBits      (flash_wr_nBits),
        .send_write_command  (send_write_command),
        .read_bitstream      (read_bitstream),
        .end_write_command   (end_write_command),
        .end_bitstream       (end_bitstream),
        .busy                (busy),
        .timeout_err         (timeout_err)
    );

    typedef struct {
        logic [2:0]  req, send, read, store;
        logic        ew, eb;
        logic [2:0]  x_ew, x_eb, x_grant;
        logic        x_busy, x_send, x_read, x_store;
        logic [31:0] x_cmd;
        logic [6:0]  x_addr;
        logic [11:0] x_nbits;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        logic [2:0] rq, logic [2:0] sd, logic [2:0] rd, logic [2:0] st, logic ew, logic eb,
        logic [2:0] xew, logic [2:0] xeb, logic [2:0] xg, logic xb, logic xs, logic xr,
        logic xst, logic [31:0] xc, logic [6:0] xa, logic [11:0] xn);
        vec_t v;
        v.req = rq; v.send = sd; v.read = rd; v.store = st; v.ew = ew; v.eb = eb;
        v.x_ew = xew; v.x_eb = xeb; v.x_grant = xg; v.x_busy = xb; v.x_send = xs;
        v.x_read = xr; v.x_store = xst; v.x_cmd = xc; v.x_addr = xa; v.x_nbits = xn;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " flash_command"}, flash_command, 32'h0);
        chk({tag, " send_wr"}, {31'b0, send_write_command}, 32'h0);
        chk({tag, " read_bs"}, {31'b0, read_bitstream}, 32'h0);
        chk({tag, " store"}, {31'b0, store_flash_command}, 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        req = '0; r_store_cmd = '0; r_send_wr = '0; r_read_bs = '0;
        end_write_command = 1'b0; end_bitstream = 1'b0;
        r_flash_cmd = {32'h2222_2222, 32'h1111_1111, 32'h0600_0000};
        r_wbuf_addr = {7'h32, 7'h21, 7'h10};
        r_wr_nbits  = {12'h102, 12'h101, 12'h100};

        //      req    send   read   store  ew eb   x_ew   x_eb   x_gr  bsy sd rd st  cmd           addr   nbits
        vq.push_back(mk(3'b000,3'b000,3'b000,3'b000,0,0, 3'b000,3'b000,3'b000,0,0,0,0, 32'h0,         7'h00, 12'h000));
        vq.push_back(mk(3'b110,3'b000,3'b000,3'b000,0,0, 3'b000,3'b000,3'b010,1,0,0,0, 32'h0,         7'h00, 12'h000));
        vq.push_back(mk(3'b110,3'b000,3'b000,3'b110,0,0, 3'b000,3'b000,3'b010,1,0,0,1, 32'h1111_1111, 7'h21, 12'h101));
        vq.push_back(mk(3'b100,3'b000,3'b000,3'b000,0,0, 3'b000,3'b000,3'b000,1,0,0,0, 32'h0,         7'h00, 12'h000));
        vq.push_back(mk(3'b100,3'b000,3'b000,3'b000,0,0, 3'b000,3'b000,3'b000,0,0,0,0, 32'h0,         7'h00, 12'h000));
        vq.push_back(mk(3'b100,3'b000,3'b000,3'b000,0,0, 3'b000,3'b000,3'b100,1,0,0,0, 32'h0,         7'h00, 12'h000));
        vq.push_back(mk(3'b100,3'b000,3'b100,3'b000,0,0, 3'b000,3'b000,3'b100,1,0,1,0, 32'h2222_2222, 7'h32, 12'h102));
        vq.push_back(mk(3'b000,3'b000,3'b000,3'b000,0,0, 3'b000,3'b000,3'b100,1,0,0,0, 32'h0,         7'h00, 12'h000));
        vq.push_back(mk(3'b000,3'b000,3'b000,3'b000,0,0, 3'b000,3'b000,3'b100,1,0,0,0, 32'h0,         7'h00, 12'h000));
        vq.push_back(mk(3'b000,3'b000,3'b000,3'b000,0,1, 3'b000,3'b100,3'b000,1,0,0,0, 32'h0,         7'h00, 12'h000));
        vq.push_back(mk(3'b000,3'b000,3'b000,3'b000,0,0, 3'b000,3'b000,3'b000,0,0,0,0, 32'h0,         7'h00, 12'h000));
        vq.push_back(mk(3'b001,3'b000,3'b000,3'b000,1,0, 3'b000,3'b000,3'b001,1,0,0,0, 32'h0,         7'h00, 12'h000));
        vq.push_back(mk(3'b001,3'b001,3'b000,3'b001,0,0, 3'b000,3'b000,3'b001,1,1,0,1, 32'h0600_0000, 7'h10, 12'h100));
        vq.push_back(mk(3'b001,3'b000,3'b000,3'b000,0,0, 3'b000,3'b000,3'b001,1,0,0,0, 32'h0600_0000, 7'h10, 12'h100));
        vq.push_back(mk(3'b001,3'b000,3'b000,3'b000,1,0, 3'b001,3'b000,3'b001,1,0,0,0, 32'h0600_0000, 7'h10, 12'h100));
        vq.push_back(mk(3'b000,3'b000,3'b000,3'b000,0,0, 3'b000,3'b000,3'b000,1,0,0,0, 32'h0,         7'h00, 12'h000));
        vq.push_back(mk(3'b000,3'b000,3'b000,3'b000,0,0, 3'b000,3'b000,3'b000,0,0,0,0, 32'h0,         7'h00, 12'h000));
        vq.push_back(mk(3'b100,3'b000,3'b000,3'b000,0,0, 3'b000,3'b000,3'b100,1,0,0,0, 32'h0,         7'h00, 12'h000));
        vq.push_back(mk(3'b101,3'b000,3'b000,3'b001,0,0, 3'b000,3'b000,3'b100,1,0,0,0, 32'h2222_2222, 7'h32, 12'h102));
        vq.push_back(mk(3'b001,3'b000,3'b000,3'b000,0,0, 3'b000,3'b000,3'b000,1,0,0,0, 32'h0,         7'h00, 12'h000));
        vq.push_back(mk(3'b001,3'b000,3'b000,3'b000,0,0, 3'b000,3'b000,3'b000,0,0,0,0, 32'h0,         7'h00, 12'h000));
        vq.push_back(mk(3'b001,3'b000,3'b000,3'b000,0,0, 3'b000,3'b000,3'b001,1,0,0,0, 32'h0,         7'h00, 12'h000));
        vq.push_back(mk(3'b000,3'b000,3'b000,3'b000,0,0, 3'b000,3'b000,3'b000,1,0,0,0, 32'h0,         7'h00, 12'h000));
        vq.push_back(mk(3'b000,3'b000,3'b000,3'b000,0,0, 3'b000,3'b000,3'b000,0,0,0,0, 32'h0,         7'h00, 12'h000));
        vq.push_back(mk(3'b010,3'b000,3'b000,3'b000,0,0, 3'b000,3'b000,3'b010,1,0,0,0, 32'h0,         7'h00, 12'h000));
        vq.push_back(mk(3'b010,3'b010,3'b000,3'b000,0,0, 3'b000,3'b000,3'b010,1,1,0,0, 32'h1111_1111, 7'h21, 12'h101));
        vq.push_back(mk(3'b000,3'b000,3'b000,3'b000,1,0, 3'b010,3'b000,3'b000,1,0,0,0, 32'h0,         7'h00, 12'h000));
        vq.push_back(mk(3'b000,3'b000,3'b000,3'b000,0,0, 3'b000,3'b000,3'b000,0,0,0,0, 32'h0,         7'h00, 12'h000));

        // reset state
        tick();
        tick();
        chk("reset grant", {29'b0, grant}, 32'h0);
        chk("reset busy", {31'b0, busy}, 32'h0);
        chk("reset timeout_err", {31'b0, timeout_err}, 32'h0);
        chk_idle_outputs("reset");
        reset = 1'b0;

        // table-driven vectors
        foreach (vq[i]) begin
            req = vq[i].req; r_send_wr = vq[i].send; r_read_bs = vq[i].read;
            r_store_cmd = vq[i].store;
            end_write_command = vq[i].ew; end_bitstream = vq[i].eb;
            #1;
            chk($sformatf("v%0d r_end_wr", i), {29'b0, r_end_wr}, {29'b0, vq[i].x_ew});
            chk($sformatf("v%0d r_end_bs", i), {29'b0, r_end_bs}, {29'b0, vq[i].x_eb});
            tick();
            chk($sformatf("v%0d grant", i), {29'b0, grant}, {29'b0, vq[i].x_grant});
            chk($sformatf("v%0d busy", i), {31'b0, busy}, {31'b0, vq[i].x_busy});
            chk($sformatf("v%0d send_wr", i), {31'b0, send_write_command}, {31'b0, vq[i].x_send});
            chk($sformatf("v%0d read_bs", i), {31'b0, read_bitstream}, {31'b0, vq[i].x_read});
            chk($sformatf("v%0d store", i), {31'b0, store_flash_command}, {31'b0, vq[i].x_store});
            chk($sformatf("v%0d flash_command", i), flash_command, vq[i].x_cmd);
            chk($sformatf("v%0d wbuf_address", i), {25'b0, wbuf_address}, {25'b0, vq[i].x_addr});
            chk($sformatf("v%0d nbits", i), {20'b0, flash_wr_nBits}, {20'b0, vq[i].x_nbits});
        end
        r_store_cmd = '0; r_send_wr = '0; r_read_bs = '0;
        end_write_command = 1'b0; end_bitstream = 1'b0;

        // watchdog: grant held 16 cycles, then dropped with sticky error
        req = 3'b010;
        repeat (16) tick();
        chk("to grant held", {29'b0, grant}, 32'h2);
        chk("to err before", {31'b0, timeout_err}, 32'h0);
        chk("to cmd forwarded", flash_command, 32'h1111_1111);
        tick();
        chk("to grant dropped", {29'b0, grant}, 32'h0);
        chk("to err set", {31'b0, timeout_err}, 32'h1);
        chk("to busy gap", {31'b0, busy}, 32'h1);
        chk_idle_outputs("to forced");
        tick();
        chk("to busy idle", {31'b0, busy}, 32'h0);
        repeat (3) tick();
        chk("to masked grant", {29'b0, grant}, 32'h0);
        chk("to masked busy", {31'b0, busy}, 32'h0);
        req = 3'b000;
        tick();
        req = 3'b010;
        tick();
        chk("to regrant", {29'b0, grant}, 32'h2);
        chk("to err sticky", {31'b0, timeout_err}, 32'h1);
        req = 3'b000;
        tick();
        tick();
        chk("to released", {31'b0, busy}, 32'h0);

        // reset while draining a bitstream read
        req = 3'b100;
        tick();
        r_read_bs = 3'b100;
        tick();
        req = 3'b000; r_read_bs = 3'b000;
        tick();
        chk("drain grant", {29'b0, grant}, 32'h4);
        chk("drain busy", {31'b0, busy}, 32'h1);
        reset = 1'b1;
        tick();
        chk("rst drain grant", {29'b0, grant}, 32'h0);
        chk("rst drain busy", {31'b0, busy}, 32'h0);
        chk("rst drain err", {31'b0, timeout_err}, 32'h0);
        chk_idle_outputs("rst drain");
        reset = 1'b0;
        tick();
        chk("post rst busy", {31'b0, busy}, 32'h0);
        chk("post rst grant", {29'b0, grant}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/flash_arbiter.md
FLASH_ARBITER -- requirements
Module: flash_arbiter

Interface
REQ-001 Parameter N_REQ, default 3: number of requesters; index 0 is the channel-programming sequencer, 1 is IPbus flash access, 2 is the master-reprogram sequencer.
REQ-002 Parameter TIMEOUT, default 24'hFF_FFFF: maximum clk cycles a grant may be held.
REQ-003 clk  in  1  system clock.
REQ-004 reset  in  1  reset, synchronous, active-high; clock clk.
REQ-005 req  in  N_REQ  per-requester ownership request, held for the whole transaction sequence.
REQ-006 grant  out  N_REQ  one-hot ownership, registered.
REQ-007 r_store_cmd  in  N_REQ  per-requester WBUF store strobe.
REQ-008 r_wbuf_addr  in  7*N_REQ  per-requester WBUF address, requester i in bits [7i+6:7i].
REQ-009 r_flash_cmd  in  32*N_REQ  per-requester flash command word.
REQ-010 r_wr_nbits  in  12*N_REQ  per-requester write bit count.
REQ-011 r_send_wr  in  N_REQ  per-requester write-command start level.
REQ-012 r_read_bs  in  N_REQ  per-requester bitstream-read start level.
REQ-013 r_end_wr  out  N_REQ  end_write_command routed to owner only.
REQ-014 r_end_bs  out  N_REQ  end_bitstream routed to owner only.
REQ-015 store_flash_command, wbuf_address[6:0], flash_command[31:0], flash_wr_nBits[11:0], send_write_command, read_bitstream  out  to spi_flash_intf, registered.
REQ-016 end_write_command, end_bitstream  in  1 each  done pulses from spi_flash_intf.
REQ-017 busy  out  1  high whenever state is not IDLE.
REQ-018 timeout_err  out  1  sticky; set on grant timeout.

Function
REQ-019 States: IDLE, GRANT, DRAIN, GAP.
REQ-020 IDLE: if any req bit is high, grant the lowest index with req high (fixed priority), load watchdog to 0, go to GRANT next cycle; grant becomes visible one cycle after req is sampled.
REQ-021 GRANT: downstream outputs equal the owner's inputs delayed one register stage; non-owner inputs are ignored.
REQ-022 GRANT: while send_write_command or read_bitstream is high, an outstanding flag is set; it clears on end_write_command or end_bitstream respectively.
REQ-023 GRANT: when owner req drops, force all downstream strobes and levels to 0 and go to DRAIN if outstanding, else GAP.
REQ-024 DRAIN: hold grant, keep downstream strobes at 0, wait for the end pulse of the outstanding command, then go to GAP.
REQ-025 GAP: grant = 0, all downstream outputs 0, exactly one cycle, then IDLE; a new grant can therefore start no sooner than 3 cycles after the previous req drops.
REQ-026 Preemption is never performed; a higher-priority req arriving during GRANT waits.
REQ-027 Watchdog increments each cycle in GRANT/DRAIN; on reaching TIMEOUT set timeout_err, drop grant, force outputs to 0, go to GAP.
REQ-028 Owner req must drop before it can be granted again after timeout; a still-high timed-out req is masked until it is seen low.
REQ-029 r_end_wr/r_end_bs are combinational AND of the downstream pulse with grant; pulses arriving in IDLE or GAP are discarded.
REQ-030 Simultaneous req drop and end pulse in GRANT: the pulse clears outstanding, go directly to GAP.
REQ-031 timeout_err clears only on reset.

Reset
REQ-032 Reset forces state IDLE, grant 0, all downstream outputs 0, watchdog 0, outstanding flags 0, timeout mask 0, timeout_err 0, busy 0.
REQ-033 Reset asserted mid-transaction takes effect on the next clk edge regardless of outstanding commands.

Structure
REQ-034 State encodings, requester index constants (REQ_CHAN, REQ_IPBUS, REQ_REPROG) and default TIMEOUT belong in a shared flash package.
REQ-035 One sub-module, flash_req_mux: registered N_REQ-to-1 field multiplexer selected by one-hot grant with forced-zero input.

Verification
REQ-036 req=3'b110 same cycle -> grant=3'b010 one cycle later; req[1] drops -> GAP, then grant=3'b100.
REQ-037 Owner 0 sends flash_command 32'h0600_0000 with send_wr -> downstream flash_command=32'h0600_0000 one cycle later; end_write_command appears only on r_end_wr[0].
REQ-038 Owner 2 drops req with read outstanding -> DRAIN, grant held until end_bitstream, then GAP and grant=0.
REQ-039 TIMEOUT=16, req[1] held -> timeout_err=1 at cycle 16 of grant, grant=0; req[1] kept high never regranted until cycled low.
REQ-040 reset during DRAIN -> next cycle grant=0, all outputs 0, busy=0.
REQ-041 end_write_command pulse while IDLE -> r_end_wr stays 3'b000.
